popcount_word_gen: RTL and testbench
====================================

# popcount_word_gen

Inverse companion to the team's ones-counter: given a population count `k`, the block emits every `WIDTH`-bit word containing exactly `k` ones, in ascending numeric order, one word per accepted beat. It sits upstream of the ones-counter in exhaustive-check and stimulus paths. Its `data_i` width matches the counter's `data_o` width, so a counter result can be fed straight back as a request.

## Interface
Parameters:
- `WIDTH`, default 32: width of generated words; must be ≥ 2.

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `arstn_i`, in, 1: reset, asynchronous and active-low.
- `data_val_i`, in, 1: request strobe; single-cycle pulse accepted in IDLE only.
- `data_i`, in, `$clog2(WIDTH)+2`: requested ones count `k`.
- `data_val_o`, out, 1: `data_o` holds a valid word.
- `data_ready_i`, in, 1: sink accepts `data_o` when high together with `data_val_o`.
- `data_o`, out, `WIDTH`: generated word.
- `last_o`, out, 1: qualifies `data_o` as the final word of the sequence.
- `busy_o`, out, 1: high in RUN.
- `err_o`, out, 1: one-cycle pulse when a request has `k > WIDTH`.

## Operation
- **Reset values:** `data_val_o`=0, `data_o`=0, `last_o`=0, `busy_o`=0, `err_o`=0, state IDLE.
- **IDLE**
  - `data_val_i`=1 and `k ≤ WIDTH`: load `word = (1<<k)-1`, latch `k`, go to RUN.
  - `data_val_i`=1 and `k > WIDTH`: pulse `err_o`, stay in IDLE.
- **RUN**
  - `data_val_o`=1 and `data_o`=`word`.
  - `last_o`=1 when `word` has exactly its top `k` bits set.
  - On an accepted beat that is not last: `word` takes the next larger word with the same popcount.
  - On an accepted beat with `last_o`=1: go to IDLE; `data_val_o` falls and `data_o` returns to 0.
- **Next-word rule** (Gosper), all arithmetic `WIDTH`-bit:
  - `c = word & -word`
  - `r = word + c`
  - `next = r | (((r ^ word) >> 2) >> ctz(c))`
  - `ctz` is a priority encoder. No dividers. Computed combinationally from the `word` register.
- **Edge cases of `k`:**
  - `k`=0: the sequence is the single word 0 with `last_o`=1.
  - `k`=`WIDTH`: the sequence is the single all-ones word with `last_o`=1.
- **Requests while busy:** `data_val_i` in RUN is ignored. No queueing, no `err_o`.
- **Backpressure:** while `data_val_o`=1 and `data_ready_i`=0, `data_o` and `last_o` hold stable.
- **Reset mid-sequence:** outputs clear immediately (asynchronously). Generation does not resume after reset.

## Timing
- **Start latency:** a request sampled at edge T gives `data_val_o`=1 with the first word after edge T (1 cycle).
- **Throughput:** one word per cycle when `data_ready_i` is held high.
- **Sequence length:** C(`WIDTH`,`k`) beats.
- **End of sequence:**
  - The last word is accepted at edge L.
  - `data_val_o`=0 and `busy_o`=0 after edge L.
  - A new request is accepted at edge L+1 at the earliest.
- **Error pulse:** a bad request at edge T raises `err_o` during cycle T+1 only.
- **Register rules:** all outputs are registered, except `last_o`, which is decoded from registered `word` and `k`.

## Configuration
- **`POPGEN_WORD_CNT_EN` defined:** adds output `word_cnt_o` [`WIDTH`-1:0].
  - Holds the 0-based index of the current word in the sequence.
  - Resets to 0 and is cleared on each accepted request.
  - Increments on each accepted non-last beat.
  - Holds its final value in IDLE until the next request.
  - `WIDTH` bits suffice, because C(`WIDTH`,`k`) < 2^`WIDTH`.
- **Macro undefined:** the port and its counter are absent. All other behaviour is identical.

## Test plan
- **`WIDTH`=4, `k`=2, `data_ready_i`=1:** words 0011, 0101, 0110, 1001, 1010, 1100 on consecutive cycles; `last_o` only on 1100; then IDLE.
- **`WIDTH`=4, edge counts:**
  - `k`=0 gives a single beat 0000 with `last_o`=1.
  - `k`=4 gives a single beat 1111 with `last_o`=1.
  - `k`=5 gives an `err_o` pulse and `data_val_o` stays 0.
- **Backpressure (`WIDTH`=4, `k`=1):** random `data_ready_i`; words 0001, 0010, 0100, 1000 each held stable until accepted; no word skipped or duplicated.
- **Ignored request:** `data_val_i` with `k`=3 pulsed mid-sequence of `k`=2 is ignored; the sequence completes unchanged.
- **Round trip (`WIDTH`=32):**
  - For `k` in {0, 1, 2, 31, 32}, each output word fed through the ones-counter returns `k`.
  - Beat counts are 1, 32, 496, 32, 1.
  - With `POPGEN_WORD_CNT_EN`, the final `word_cnt_o` is the beat count minus 1.
- **Reset mid-sequence:** `arstn_i` low mid-sequence clears `data_val_o` and `data_o` without waiting for a clock edge. After release, a request with `k`=2 restarts from 0011.

Source files
------------

// File: rtl/popcount_word_gen.sv
// popcount_word_gen: emits every WIDTH-bit word with exactly k ones, ascending.
// Optional POPGEN_WORD_CNT_EN adds word_cnt_o, the index of the current word.
module popcount_word_gen #(
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic                       data_val_i,
    input  logic [$clog2(WIDTH)+1:0]   data_i,
    output logic                       data_val_o,
    input  logic                       data_ready_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       last_o,
    output logic                       busy_o,
`ifdef POPGEN_WORD_CNT_EN
    output logic [WIDTH-1:0]           word_cnt_o,
`endif
    output logic                       err_o
);

    localparam int KW = $clog2(WIDTH) + 2;
    localparam int CW = $clog2(WIDTH);
    localparam logic [KW-1:0] KMAX = KW'(WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_nxt;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_nxt;
    logic             err_q;
    logic             err_nxt;

    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] succ;
    logic [CW-1:0]    ctz;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] top_mask;
    logic             accept;
    logic             req_ok;
    logic             req_bad;

    assign accept  = (state == RUN) && data_ready_i;
    assign req_ok  = (state == IDLE) && data_val_i && (data_i <= KMAX);
    assign req_bad = (state == IDLE) && data_val_i && (data_i > KMAX);

    // Gosper successor: isolate lowest set bit, ripple it, refill low ones.
    assign c    = word & (~word + WIDTH'(1));
    assign r    = word + c;
    assign succ = r | (((r ^ word) >> 2) >> ctz);

    // First word has the k low bits set; k == WIDTH shifts everything out.
    assign load_word = ~({WIDTH{1'b1}} << data_i);
    // Final word has the k top bits set; k == 0 gives the empty mask.
    assign top_mask  = ~({WIDTH{1'b1}} >> k_q);

    assign data_val_o = (state == RUN);
    assign busy_o     = (state == RUN);
    assign data_o     = word;
    assign err_o      = err_q;
    assign last_o     = (state == RUN) && (word == top_mask);

    // Trailing-zero count of the isolated low bit; lowest index wins.
    always_comb begin
        ctz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (c[i]) begin
                ctz = CW'(i);
            end
        end
    end

    // Next-state and next-word selection.
    always_comb begin
        state_nxt = state;
        word_nxt  = word;
        k_nxt     = k_q;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_ok) begin
                    state_nxt = RUN;
                    word_nxt  = load_word;
                    k_nxt     = data_i;
                end else if (req_bad) begin
                    err_nxt = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_o) begin
                        state_nxt = IDLE;
                        word_nxt  = '0;
                    end else begin
                        word_nxt = succ;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                word_nxt  = '0;
            end
        endcase
    end

    // State, word and request registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state <= IDLE;
            word  <= '0;
            k_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            word  <= word_nxt;
            k_q   <= k_nxt;
            err_q <= err_nxt;
        end
    end

`ifdef POPGEN_WORD_CNT_EN
    logic [WIDTH-1:0] cnt;

    assign word_cnt_o = cnt;

    // Index of the presented word; holds after the last beat.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt <= '0;
        end else if (req_ok) begin
            cnt <= '0;
        end else if (accept && !last_o) begin
            cnt <= cnt + WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_popcount_word_gen.sv
// Bench for popcount_word_gen: WIDTH=4 and WIDTH=32 instances.
// Scoreboard queue of expected words from an independent enumeration.
module tb_popcount_word_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arstn;

    logic        v4_in;
    logic [3:0]  k4;
    logic        rdy4;
    logic        v4_out;
    logic [3:0]  d4;
    logic        l4;
    logic        b4;
    logic        e4;

    logic        v32_in;
    logic [6:0]  k32;
    logic        rdy32;
    logic        v32_out;
    logic [31:0] d32;
    logic        l32;
    logic        b32;
    logic        e32;

`ifdef POPGEN_WORD_CNT_EN
    logic [3:0]  c4;
    logic [31:0] c32;
`endif

    popcount_word_gen #(.WIDTH(4)) dut4 (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .data_val_i   (v4_in),
        .data_i       (k4),
        .data_val_o   (v4_out),
        .data_ready_i (rdy4),
        .data_o       (d4),
        .last_o       (l4),
        .busy_o       (b4),
`ifdef POPGEN_WORD_CNT_EN
        .word_cnt_o   (c4),
`endif
        .err_o        (e4)
    );

    popcount_word_gen #(.WIDTH(32)) dut32 (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .data_val_i   (v32_in),
        .data_i       (k32),
        .data_val_o   (v32_out),
        .data_ready_i (rdy32),
        .data_o       (d32),
        .last_o       (l32),
        .busy_o       (b32),
`ifdef POPGEN_WORD_CNT_EN
        .word_cnt_o   (c32),
`endif
        .err_o        (e32)
    );

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] o_data(input bit s);
        return s ? d32 : {28'b0, d4};
    endfunction

    function automatic logic o_val(input bit s);
        return s ? v32_out : v4_out;
    endfunction

    function automatic logic o_last(input bit s);
        return s ? l32 : l4;
    endfunction

    function automatic logic o_busy(input bit s);
        return s ? b32 : b4;
    endfunction

    function automatic logic o_err(input bit s);
        return s ? e32 : e4;
    endfunction

`ifdef POPGEN_WORD_CNT_EN
    function automatic logic [31:0] o_cnt(input bit s);
        return s ? c32 : {28'b0, c4};
    endfunction
`endif

    task automatic set_ready(input bit s, input logic r);
        if (s) rdy32 = r;
        else   rdy4  = r;
    endtask

    // Returns at the negedge following the edge that samples the request.
    task automatic request(input bit s, input int k);
        @(negedge clk);
        if (s) begin
            v32_in = 1'b1;
            k32    = k[6:0];
        end else begin
            v4_in = 1'b1;
            k4    = k[3:0];
        end
        @(negedge clk);
        v4_in  = 1'b0;
        v32_in = 1'b0;
    endtask

    // Independent enumeration of the expected ascending sequence.
    task automatic push_seq(input bit s, input int k);
        if (!s) begin
            for (int w = 0; w < 16; w++) begin
                if ($countones(w[3:0]) == k) exp_q.push_back(32'(w));
            end
        end else begin
            case (k)
                0: exp_q.push_back(32'h0);
                1: for (int i = 0; i < 32; i++) exp_q.push_back(32'(1) << i);
                2: for (int hi = 1; hi < 32; hi++)
                       for (int lo = 0; lo < hi; lo++)
                           exp_q.push_back((32'(1) << hi) | (32'(1) << lo));
                31: for (int i = 31; i >= 0; i--)
                        exp_q.push_back(~(32'(1) << i));
                default: exp_q.push_back(32'hFFFF_FFFF);
            endcase
        end
    endtask

    // Consume the sequence; mode 1 randomises ready; inject >= 0 pulses k=3.
    task automatic drain(input bit s, input int k, input int mode,
                         input int inject);
        int          beats = 0;
        int          n;
        bit          hold = 0;
        bit          done = 0;
        bit          injected = 0;
        logic [31:0] held;
        logic        held_last;
        logic [31:0] want;
        logic        r;
        n = exp_q.size();
        check("start_valid", 32'(o_val(s)), 32'd1);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (hold) begin
                check("hold_data", o_data(s), held);
                check("hold_last", 32'(o_last(s)), 32'(held_last));
            end
            r = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            set_ready(s, r);
            if (!injected && inject >= 0 && beats == inject) begin
                injected = 1;
                v4_in = 1'b1;
                k4 = 4'd3;
            end
            if (o_val(s) && r) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", o_data(s), 32'hDEAD_BEEF);
                    done = 1;
                end else begin
                    want = exp_q.pop_front();
                    check("data", o_data(s), want);
                    check("last", 32'(o_last(s)), 32'(exp_q.size() == 0));
                    check("busy", 32'(o_busy(s)), 32'd1);
                    if (s) check("ones", 32'($countones(o_data(s))), 32'(k));
`ifdef POPGEN_WORD_CNT_EN
                    check("word_cnt", o_cnt(s), 32'(beats));
`endif
                    beats++;
                    if (o_last(s)) done = 1;
                end
                hold = 0;
            end else if (o_val(s)) begin
                hold = 1;
                held = o_data(s);
                held_last = o_last(s);
            end
            @(negedge clk);
            v4_in = 1'b0;
        end
        check("seq_done", 32'(done), 32'd1);
        check("beats", 32'(beats), 32'(n));
        check("end_valid", 32'(o_val(s)), 32'd0);
        check("end_busy", 32'(o_busy(s)), 32'd0);
        check("end_data", o_data(s), 32'd0);
        check("no_err", 32'(o_err(s)), 32'd0);
`ifdef POPGEN_WORD_CNT_EN
        check("final_cnt", o_cnt(s), 32'(n - 1));
`endif
        exp_q.delete();
        set_ready(s, 1'b0);
    endtask

    initial begin
        arstn  = 1'b0;
        v4_in  = 1'b0;
        k4     = '0;
        rdy4   = 1'b0;
        v32_in = 1'b0;
        k32    = '0;
        rdy32  = 1'b0;
        #12;
        check("rst_val4", 32'(v4_out), 32'd0);
        check("rst_data4", 32'(d4), 32'd0);
        check("rst_last4", 32'(l4), 32'd0);
        check("rst_busy4", 32'(b4), 32'd0);
        check("rst_err4", 32'(e4), 32'd0);
        check("rst_val32", 32'(v32_out), 32'd0);
        check("rst_data32", d32, 32'd0);
        @(negedge clk);
        arstn = 1'b1;

        // W4 k=2, ready held high
        push_seq(0, 2);
        request(0, 2);
        drain(0, 2, 0, -1);

        // W4 edge counts
        push_seq(0, 0);
        request(0, 0);
        drain(0, 0, 0, -1);
        push_seq(0, 4);
        request(0, 4);
        drain(0, 4, 0, -1);

        // W4 k=5 is rejected with a one-cycle error pulse
        request(0, 5);
        check("err_pulse", 32'(e4), 32'd1);
        check("err_no_val", 32'(v4_out), 32'd0);
        @(negedge clk);
        check("err_clear", 32'(e4), 32'd0);
        check("err_still_idle", 32'(v4_out), 32'd0);

        // W4 k=1 under random backpressure
        push_seq(0, 1);
        request(0, 1);
        drain(0, 1, 1, -1);

        // W4 k=2 with a k=3 request pulsed mid-sequence
        push_seq(0, 2);
        request(0, 2);
        drain(0, 2, 0, 2);

        // W32 round trip
        push_seq(1, 0);
        request(1, 0);
        drain(1, 0, 0, -1);
        push_seq(1, 1);
        request(1, 1);
        drain(1, 1, 0, -1);
        push_seq(1, 2);
        request(1, 2);
        drain(1, 2, 0, -1);
        push_seq(1, 31);
        request(1, 31);
        drain(1, 31, 1, -1);
        push_seq(1, 32);
        request(1, 32);
        drain(1, 32, 0, -1);

        // Asynchronous reset mid-sequence, then restart
        request(0, 2);
        rdy4 = 1'b1;
        @(negedge clk);
        check("pre_rst_val", 32'(v4_out), 32'd1);
        #2;
        arstn = 1'b0;
        #1;
        check("async_val", 32'(v4_out), 32'd0);
        check("async_data", 32'(d4), 32'd0);
        check("async_busy", 32'(b4), 32'd0);
        rdy4 = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(v4_out), 32'd0);
        push_seq(0, 2);
        request(0, 2);
        check("restart_first", 32'(d4), 32'h3);
        drain(0, 2, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
